coord_pio_pixel_sink: RTL and testbench
=======================================

Name: coord_pio_pixel_sink

Overview:
- FPGA-side consumer of the HPS coordinate PIO exports (x_coordinate / y_coordinate 32-bit words).
- HPS software writes a coordinate pair and commits it by flipping a toggle bit. This block detects each commit, range-checks it against the 640x480 frame, and queues a 16-bit-colour pixel write.
- Queued writes are issued to the pixel-buffer writer over a valid/ready handshake.

Parameters:
- H_RES, 640, frame width in pixels; valid x is 0..H_RES-1
- V_RES, 480, frame height in pixels; valid y is 0..V_RES-1
- FIFO_DEPTH, 8, pending pixel-write entries; power of two, minimum 2
- ADDR_W, 19, pixel address width; pix_addr = y*H_RES + x

Ports:
- clk_clk  input  1  system clock, same clock as the PIO registers
- reset_reset_n  input  1  reset: synchronous, active-low
- x_coordinate_export  input  32  [9:0] x, [15:10] ignored, [31:16] RGB565 colour
- y_coordinate_export  input  32  [8:0] y, [30:9] ignored, [31] commit toggle
- pix_valid  output  1  pixel write request valid
- pix_ready  input  1  downstream accepts the current request
- pix_addr  output  ADDR_W  linear pixel address
- pix_data  output  16  RGB565 colour
- drop_count  output  16  saturating count of out-of-range commits
- overflow  output  1  sticky; set when a commit arrives with the FIFO full
- busy  output  1  FIFO non-empty or a commit is in the pipeline

Behaviour:
- Reset is synchronous, active-low. Reset values:
  - pix_valid=0, pix_addr=0, pix_data=0
  - drop_count=0, overflow=0, busy=0
  - FIFO emptied
  - toggle history register loaded from y_coordinate_export[31] on the reset cycle, so no spurious commit at release.
- Input stage: both export words are registered once (stage S0). A commit is detected when registered y[31] differs from the toggle history; the history then updates the same cycle.
  - Multiple toggles are never merged: one edge produces one commit.
  - Two toggles on consecutive cycles produce two commits.
- Commit pipeline:
  - S1: range check (x < H_RES and y < V_RES).
  - S2: address computation y*H_RES + x in ADDR_W bits. Computed via shift-add (y<<9 + y<<7 for 640), or by a generic multiply when H_RES is not 640.
  - FIFO push at end of S2.
  - Commit-to-pix_valid latency: 4 cycles when the FIFO is empty and pix_ready=1.
- Out-of-range commit: not pushed; drop_count += 1, saturating at 0xFFFF (no wrap).
- FIFO full at push: entry discarded; overflow set and held until reset. drop_count is unchanged.
- Simultaneous push and pop with the FIFO full: pop first, push succeeds, overflow not set.
- Output handshake:
  - pix_valid = FIFO non-empty; pix_addr/pix_data show the head entry.
  - A transfer occurs on a cycle with pix_valid && pix_ready; head advances next cycle.
  - While pix_valid=1 and pix_ready=0, pix_addr/pix_data hold stable.
  - pix_valid never drops without a transfer.
- FIFO pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- busy = FIFO non-empty OR a valid commit in S1/S2.
- Reset mid-operation: pipeline and FIFO flushed in the same cycle; outputs take reset values on the next edge.
- Non-toggle changes to the x/y words never produce a write.

Optional Feature:
- Macro COORD_CLIP_EN.
- Defined: out-of-range coordinates are clamped (x to H_RES-1, y to V_RES-1) and pushed; drop_count stays 0.
- Undefined: out-of-range commits are dropped and counted as described above.

Test Plan:
- Single commit: x=0x001F_0005 (colour 0x001F, x=5), y toggles to 0x8000_0003, pix_ready=1 -> after 4 cycles pix_valid=1, pix_addr=1925, pix_data=0x001F, one transfer.
- Backpressure: pix_ready=0, commit 3 pairs -> pix_valid stays 1 with the first entry stable; release pix_ready -> 3 transfers in commit order, busy falls after the last.
- Overflow: pix_ready=0, commit FIFO_DEPTH+2 valid pairs -> FIFO_DEPTH entries delivered, overflow=1, drop_count=0.
- Range check: commit x=640,y=0 and x=0,y=480 -> no pix_valid, drop_count=2; with COORD_CLIP_EN -> addrs 639 and 306560.
- Corner address: x=639, y=479 -> pix_addr=307199.
- Reset and toggle edges: assert reset_reset_n=0 mid-burst with y[31]=1 held -> outputs clear, no commit after release. Then toggle y[31] on two consecutive cycles -> exactly 2 writes.

Source files
------------

// File: rtl/coord_pio_pixel_sink.sv
// coord_pio_pixel_sink: turns toggle-committed HPS coordinate PIO words into
// range-checked RGB565 pixel writes, queued and issued over valid/ready.
// Optional build macro COORD_CLIP_EN: clamp out-of-range coordinates to the
// frame edge and write them instead of dropping and counting them.
module coord_pio_pixel_sink #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       x_coordinate_export,
    input  logic [31:0]       y_coordinate_export,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    localparam int unsigned COL_W = 16;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [COL_W-1:0]  col;
    } pix_entry_t;

    // S0 capture
    logic [X_W-1:0]   s0_x;
    logic [Y_W-1:0]   s0_y;
    logic [COL_W-1:0] s0_col;
    logic             s0_tog;
    logic             tog_hist;
    logic             commit;

    // S1 / S2 pipeline
    logic             s1_valid;
    logic [X_W-1:0]   s1_x;
    logic [Y_W-1:0]   s1_y;
    logic [COL_W-1:0] s1_col;
    logic             x_ok;
    logic             y_ok;
    logic             s2_valid;
    logic [X_W-1:0]   s2_x;
    logic [Y_W-1:0]   s2_y;
    logic [COL_W-1:0] s2_col;
    logic [ADDR_W-1:0] s2_addr;

    // FIFO
    pix_entry_t       mem [FIFO_DEPTH];
    pix_entry_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

    // Ignored PIO bits, collected so they are visibly consumed
    logic             unused_bits;
    assign unused_bits = ^{x_coordinate_export[15:10], y_coordinate_export[30:9]};

    // S0: register both export words every cycle, including during reset,
    // so the toggle history and S0 agree at release
    always_ff @(posedge clk_clk) begin
        s0_x   <= x_coordinate_export[X_W-1:0];
        s0_y   <= y_coordinate_export[Y_W-1:0];
        s0_col <= x_coordinate_export[31:16];
        s0_tog <= y_coordinate_export[31];
    end

    // Toggle history: seeded from the live bit in reset, then follows S0
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            tog_hist <= y_coordinate_export[31];
        end else begin
            tog_hist <= s0_tog;
        end
    end

    assign commit = s0_tog ^ tog_hist;

    // S1: hold the committed coordinate for the range check
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= commit;
        end
        s1_x   <= s0_x;
        s1_y   <= s0_y;
        s1_col <= s0_col;
    end

    assign x_ok = 32'(s1_x) < H_RES;
    assign y_ok = 32'(s1_y) < V_RES;

`ifdef COORD_CLIP_EN
    // S1->S2: clamp to the frame edge; nothing is ever dropped
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s2_valid   <= 1'b0;
            drop_count <= '0;
        end else begin
            s2_valid   <= s1_valid;
            drop_count <= '0;
        end
        s2_x   <= x_ok ? s1_x : X_W'(H_RES - 1);
        s2_y   <= y_ok ? s1_y : Y_W'(V_RES - 1);
        s2_col <= s1_col;
    end
`else
    // S1->S2: pass in-range commits, count the rest (saturating)
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s2_valid   <= 1'b0;
            drop_count <= '0;
        end else begin
            s2_valid <= s1_valid && x_ok && y_ok;
            if (s1_valid && !(x_ok && y_ok) && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
        s2_x   <= s1_x;
        s2_y   <= s1_y;
        s2_col <= s1_col;
    end
`endif

    // S2: linear address, shift-add for the standard 640-wide frame
    generate
        if (H_RES == 640) begin : g_addr_640
            assign s2_addr = (ADDR_W'(s2_y) << 9) + (ADDR_W'(s2_y) << 7) + ADDR_W'(s2_x);
        end else begin : g_addr_mul
            assign s2_addr = ADDR_W'(s2_y) * ADDR_W'(H_RES) + ADDR_W'(s2_x);
        end
    endgenerate

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && pix_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = s2_valid && (!fifo_full || pop);

    // FIFO pointers and sticky overflow
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (s2_valid && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{addr: s2_addr, col: s2_col};
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign pix_valid = !fifo_empty;
    assign pix_addr  = pix_valid ? head.addr : '0;
    assign pix_data  = pix_valid ? head.col  : '0;
    assign busy      = !fifo_empty || s1_valid || s2_valid;

endmodule

// File: tb/tb_coord_pio_pixel_sink.sv
// Directed bench for coord_pio_pixel_sink (default or COORD_CLIP_EN build).
module tb_coord_pio_pixel_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [18:0] pix_addr;
    logic [15:0] pix_data;
    logic [15:0] drop_count;
    logic        overflow;
    logic        busy;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic        tog    = 1'b0;
    logic [18:0] got_addr [$];
    logic [15:0] got_data [$];

    coord_pio_pixel_sink dut (
        .clk_clk             (clk),
        .reset_reset_n       (rst_n),
        .x_coordinate_export (x_in),
        .y_coordinate_export (y_in),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .pix_addr            (pix_addr),
        .pix_data            (pix_data),
        .drop_count          (drop_count),
        .overflow            (overflow),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a coordinate pair and flip the commit bit, then advance one cycle
    task automatic commit(input logic [9:0] cx, input logic [8:0] cy, input logic [15:0] col);
        x_in = {col, 6'b0, cx};
        tog  = ~tog;
        y_in = {tog, 22'b0, cy};
        step(1);
    endtask

    // Record every transfer seen over a fixed window (pix_ready held by caller)
    task automatic collect(input int cycles);
        got_addr.delete();
        got_data.delete();
        for (int i = 0; i < cycles; i++) begin
            if (pix_valid && pix_ready) begin
                got_addr.push_back(pix_addr);
                got_data.push_back(pix_data);
            end
            step(1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        pix_ready = 1'b1;
        step(3);

        // Reset state
        chk("rst_valid",    32'(pix_valid),  32'd0);
        chk("rst_addr",     32'(pix_addr),   32'd0);
        chk("rst_data",     32'(pix_data),   32'd0);
        chk("rst_drop",     32'(drop_count), 32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle_valid", 32'(pix_valid), 32'd0);

        // Single commit: 4-cycle latency, address 3*640+5
        commit(10'd5, 9'd3, 16'h001F);
        step(2);
        chk("lat_valid_early", 32'(pix_valid), 32'd0);
        chk("lat_busy",        32'(busy),      32'd1);
        step(1);
        chk("lat_valid",  32'(pix_valid), 32'd1);
        chk("lat_addr",   32'(pix_addr),  32'd1925);
        chk("lat_data",   32'(pix_data),  32'h001F);
        step(1);
        chk("single_done_valid", 32'(pix_valid), 32'd0);
        chk("single_done_busy",  32'(busy),      32'd0);

        // Backpressure: three entries held, then drained in order
        pix_ready = 1'b0;
        commit(10'd1, 9'd1, 16'hAAAA);
        commit(10'd2, 9'd1, 16'hBBBB);
        commit(10'd3, 9'd1, 16'hCCCC);
        step(4);
        chk("bp_valid", 32'(pix_valid), 32'd1);
        chk("bp_addr",  32'(pix_addr),  32'd641);
        chk("bp_data",  32'(pix_data),  32'hAAAA);
        step(3);
        chk("bp_hold_valid", 32'(pix_valid), 32'd1);
        chk("bp_hold_addr",  32'(pix_addr),  32'd641);
        chk("bp_hold_data",  32'(pix_data),  32'hAAAA);
        pix_ready = 1'b1;
        chk("bp_head0", 32'(pix_addr), 32'd641);
        step(1);
        chk("bp_head1", 32'(pix_addr), 32'd642);
        chk("bp_data1", 32'(pix_data), 32'hBBBB);
        step(1);
        chk("bp_head2", 32'(pix_addr), 32'd643);
        chk("bp_data2", 32'(pix_data), 32'hCCCC);
        chk("bp_busy2", 32'(busy),     32'd1);
        step(1);
        chk("bp_empty_valid", 32'(pix_valid), 32'd0);
        chk("bp_empty_busy",  32'(busy),      32'd0);

        // Overflow: ten commits into an eight-deep FIFO
        pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            commit(10'(i), 9'd2, 16'(i + 16'h0100));
        end
        step(4);
        chk("ovf_flag",  32'(overflow),   32'd1);
        chk("ovf_drop",  32'(drop_count), 32'd0);
        chk("ovf_valid", 32'(pix_valid),  32'd1);
        pix_ready = 1'b1;
        collect(14);
        chk("ovf_count", 32'(got_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_addr.size()) begin
                chk($sformatf("ovf_addr%0d", i), 32'(got_addr[i]), 32'(1280 + i));
                chk($sformatf("ovf_data%0d", i), 32'(got_data[i]), 32'(i + 16'h0100));
            end
        end

        // Range check at both frame edges
        commit(10'd640, 9'd0,   16'h1234);
        commit(10'd0,   9'd480, 16'h5678);
        collect(8);
`ifdef COORD_CLIP_EN
        chk("rng_count", 32'(got_addr.size()), 32'd2);
        if (got_addr.size() == 2) begin
            chk("rng_addr_x", 32'(got_addr[0]), 32'd639);
            chk("rng_addr_y", 32'(got_addr[1]), 32'd306560);
            chk("rng_data_y", 32'(got_data[1]), 32'h5678);
        end
        chk("rng_drop", 32'(drop_count), 32'd0);
`else
        chk("rng_count", 32'(got_addr.size()), 32'd0);
        chk("rng_drop",  32'(drop_count),      32'd2);
`endif
        chk("rng_ovf_sticky", 32'(overflow), 32'd1);

        // Corner address
        commit(10'd639, 9'd479, 16'hF800);
        collect(8);
        chk("corner_count", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() == 1) begin
            chk("corner_addr", 32'(got_addr[0]), 32'd307199);
            chk("corner_data", 32'(got_data[0]), 32'hF800);
        end

        // Reset mid-burst with the commit bit held high
        pix_ready = 1'b0;
        commit(10'd7, 9'd7, 16'h0707);
        commit(10'd8, 9'd7, 16'h0808);
        if (tog == 1'b0) begin
            commit(10'd9, 9'd7, 16'h0909);
        end
        step(1);
        rst_n = 1'b0;
        step(2);
        chk("mid_rst_valid", 32'(pix_valid),  32'd0);
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_ovf",   32'(overflow),   32'd0);
        chk("mid_rst_drop",  32'(drop_count), 32'd0);
        chk("mid_rst_addr",  32'(pix_addr),   32'd0);
        rst_n     = 1'b1;
        pix_ready = 1'b1;
        collect(8);
        chk("post_rst_writes", 32'(got_addr.size()), 32'd0);
        chk("post_rst_busy",   32'(busy),            32'd0);

        // Toggles on two consecutive cycles give two writes
        commit(10'd10, 9'd10, 16'h1111);
        commit(10'd11, 9'd10, 16'h2222);
        collect(10);
        chk("dbl_count", 32'(got_addr.size()), 32'd2);
        if (got_addr.size() == 2) begin
            chk("dbl_addr0", 32'(got_addr[0]), 32'd6410);
            chk("dbl_data0", 32'(got_data[0]), 32'h1111);
            chk("dbl_addr1", 32'(got_addr[1]), 32'd6411);
            chk("dbl_data1", 32'(got_data[1]), 32'h2222);
        end

        // Changing the words without toggling writes nothing
        x_in = {16'hFFFF, 6'b0, 10'd20};
        y_in = {tog, 22'b0, 9'd20};
        step(1);
        x_in = {16'h0F0F, 6'b0, 10'd21};
        collect(8);
        chk("no_toggle_writes", 32'(got_addr.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
